// File: rtl/emesh_rx_unpack.sv
// Reassembles LW-bit link beats into one emesh packet and decodes it into fields.
// Optional saturating frame-error counter: define EMESH_RX_UNPACK_ERRCNT_EN.
module emesh_rx_unpack #(
  parameter int AW = 32,
  parameter int PW = 2 * AW + 40,
  parameter int LW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          link_valid_in,
  input  logic          link_last_in,
  input  logic [LW-1:0] link_data_in,
  output logic          link_ready_out,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          write_out,
  output logic [1:0]    datamode_out,
  output logic [4:0]    ctrlmode_out,
  output logic [AW-1:0] dstaddr_out,
  output logic [AW-1:0] srcaddr_out,
  output logic [AW-1:0] data_out,
  output logic          frame_err_out
`ifdef EMESH_RX_UNPACK_ERRCNT_EN
  ,
  output logic [7:0]    err_count_out
`endif
);

  localparam int NB = (PW + LW - 1) / LW;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CW-1:0] LastCnt = CW'(NB - 1);

  if (AW != 32 && AW != 64) begin : g_bad_aw
    $error("emesh_rx_unpack: AW must be 32 or 64");
  end
  if ((LW % 8) != 0 || LW < 8 || LW > PW) begin : g_bad_lw
    $error("emesh_rx_unpack: LW must be a multiple of 8 in [8, PW]");
  end
  if (PW < 2 * AW + 40) begin : g_bad_pw
    $error("emesh_rx_unpack: PW too small for the decoded fields");
  end

  logic [CW-1:0]    r_cnt;
  logic [NB*LW-1:0] r_pkt;
  logic             r_valid;
  logic             r_write;
  logic [1:0]       r_dm;
  logic [4:0]       r_ctrl;
  logic [AW-1:0]    r_dst;
  logic [AW-1:0]    r_src;
  logic [AW-1:0]    r_data;
  logic             r_frame_err;

  logic [NB*LW-1:0] w_pkt;
  logic             w_last_cnt;
  logic             w_accept;
  logic             w_done;
  logic             w_err;
  logic             w_write;
  logic [1:0]       w_dm;
  logic [4:0]       w_ctrl;
  logic [AW-1:0]    w_dst;
  logic [AW-1:0]    w_src;
  logic [AW-1:0]    w_data;
  logic             w_unused;

  // Decode sees the stored beats merged with the beat currently on the link.
  always_comb begin
    w_pkt = r_pkt;
    w_pkt[r_cnt*LW +: LW] = link_data_in;
  end

  assign w_last_cnt     = (r_cnt == LastCnt);
  assign link_ready_out = ~w_last_cnt | ~r_valid | out_ready;
  assign w_accept       = link_valid_in & link_ready_out;
  assign w_done         = w_accept & w_last_cnt & link_last_in;
  // Short packet (last too early) or long packet (no last on final beat).
  assign w_err          = w_accept & (link_last_in ^ w_last_cnt);

  assign w_write = w_pkt[0];
  assign w_dm    = w_pkt[2:1];

  if (AW == 64) begin : g_aw64
    assign w_ctrl = w_pkt[7:3];
    assign w_dst  = {w_pkt[167:136], w_pkt[39:8]};
    assign w_data = w_pkt[103:40];
    assign w_src  = w_pkt[135:72];
  end else begin : g_aw32
    assign w_ctrl = {1'b0, w_pkt[6:3]};
    assign w_dst  = w_pkt[39:8];
    assign w_data = w_pkt[71:40];
    assign w_src  = w_pkt[103:72];
  end

  assign w_unused = ^w_pkt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt       <= '0;
      r_pkt       <= '0;
      r_valid     <= 1'b0;
      r_write     <= 1'b0;
      r_dm        <= '0;
      r_ctrl      <= '0;
      r_dst       <= '0;
      r_src       <= '0;
      r_data      <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_err;
      if (w_accept) begin
        r_pkt[r_cnt*LW +: LW] <= link_data_in;
        r_cnt <= (link_last_in || w_last_cnt) ? '0 : r_cnt + 1'b1;
      end
      if (w_done) begin
        r_valid <= 1'b1;
        r_write <= w_write;
        r_dm    <= w_dm;
        r_ctrl  <= w_ctrl;
        r_dst   <= w_dst;
        r_src   <= w_src;
        r_data  <= w_data;
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_valid     = r_valid;
  assign write_out     = r_write;
  assign datamode_out  = r_dm;
  assign ctrlmode_out  = r_ctrl;
  assign dstaddr_out   = r_dst;
  assign srcaddr_out   = r_src;
  assign data_out      = r_data;
  assign frame_err_out = r_frame_err;

`ifdef EMESH_RX_UNPACK_ERRCNT_EN
  logic [7:0] r_err_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_err_count <= '0;
    end else if (r_frame_err && (r_err_count != 8'hFF)) begin
      r_err_count <= r_err_count + 8'd1;
    end
  end

  assign err_count_out = r_err_count;
`endif

endmodule

// File: tb/tb_emesh_rx_unpack.sv
// Scoreboard bench for emesh_rx_unpack: random framed traffic on an AW=32 instance,
// directed decode checks on an AW=64 instance.
module tb_emesh_rx_unpack;

  localparam int NB = 4;

  typedef struct {
    logic        w;
    logic [1:0]  dm;
    logic [4:0]  ctrl;
    logic [63:0] dst;
    logic [63:0] src;
    logic [63:0] data;
    int          avail;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        link_valid_in = 1'b0;
  logic        link_last_in = 1'b0;
  logic [31:0] link_data_in = '0;
  logic        link_ready_out;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        write_out;
  logic [1:0]  datamode_out;
  logic [4:0]  ctrlmode_out;
  logic [31:0] dstaddr_out;
  logic [31:0] srcaddr_out;
  logic [31:0] data_out;
  logic        frame_err_out;
  logic [7:0]  err_count;

  logic        v64 = 1'b0;
  logic        last64 = 1'b0;
  logic [31:0] d64 = '0;
  logic        rdy64;
  logic        ov64;
  logic        w64;
  logic [1:0]  dm64;
  logic [4:0]  ctrl64;
  logic [63:0] dst64;
  logic [63:0] src64;
  logic [63:0] data64;
  logic        ferr64;
  logic [7:0]  err_count64;

  emesh_rx_unpack #(.AW(32), .LW(32)) u_dut (
    .clk           (clk),
    .reset         (reset),
    .link_valid_in (link_valid_in),
    .link_last_in  (link_last_in),
    .link_data_in  (link_data_in),
    .link_ready_out(link_ready_out),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .write_out     (write_out),
    .datamode_out  (datamode_out),
    .ctrlmode_out  (ctrlmode_out),
    .dstaddr_out   (dstaddr_out),
    .srcaddr_out   (srcaddr_out),
    .data_out      (data_out),
    .frame_err_out (frame_err_out)
`ifdef EMESH_RX_UNPACK_ERRCNT_EN
    ,
    .err_count_out (err_count)
`endif
  );

  emesh_rx_unpack #(.AW(64), .LW(32)) u_dut64 (
    .clk           (clk),
    .reset         (reset),
    .link_valid_in (v64),
    .link_last_in  (last64),
    .link_data_in  (d64),
    .link_ready_out(rdy64),
    .out_valid     (ov64),
    .out_ready     (1'b1),
    .write_out     (w64),
    .datamode_out  (dm64),
    .ctrlmode_out  (ctrl64),
    .dstaddr_out   (dst64),
    .srcaddr_out   (src64),
    .data_out      (data64),
    .frame_err_out (ferr64)
`ifdef EMESH_RX_UNPACK_ERRCNT_EN
    ,
    .err_count_out (err_count64)
`endif
  );

  exp_t exp_q[$];
  int   err_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   pos = 0;
  int   err_total = 0;
  int   rdy_pct = 100;
  bit   idle_en = 1'b0;
  logic mon_err_exp;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: front of the queue must be on the outputs once due; pop on handshake.
  always @(negedge clk) begin
    if (!reset) begin
      mon_err_exp = 1'b0;
      while (err_q.size() > 0 && err_q[0] <= cyc) begin
        if (err_q[0] == cyc) mon_err_exp = 1'b1;
        void'(err_q.pop_front());
      end
      chk("frame_err", {63'd0, frame_err_out}, {63'd0, mon_err_exp});
      if (exp_q.size() > 0 && exp_q[0].avail <= cyc) begin
        chk("out_valid", {63'd0, out_valid}, 64'd1);
        chk("write", {63'd0, write_out}, {63'd0, exp_q[0].w});
        chk("datamode", {62'd0, datamode_out}, {62'd0, exp_q[0].dm});
        chk("ctrlmode", {59'd0, ctrlmode_out}, {59'd0, exp_q[0].ctrl});
        chk("dstaddr", {32'd0, dstaddr_out}, exp_q[0].dst);
        chk("data", {32'd0, data_out}, exp_q[0].data);
        chk("srcaddr", {32'd0, srcaddr_out}, exp_q[0].src);
        if (out_ready) void'(exp_q.pop_front());
      end else begin
        chk("out_valid_idle", {63'd0, out_valid}, 64'd0);
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      link_valid_in = 1'b0;
      link_last_in  = $urandom_range(0, 1);
      link_data_in  = $urandom;
      out_ready     = ($urandom_range(0, 99) < rdy_pct);
    end
  endtask

  task automatic drive_beat(input logic [31:0] d, input logic last, input exp_t e);
    bit   acc = 1'b0;
    int   guard = 0;
    bit   pending;
    logic exp_rdy;
    exp_t ee = e;
    while (!acc) begin
      @(posedge clk); #1;
      link_valid_in = 1'b1;
      link_data_in  = d;
      link_last_in  = last;
      out_ready     = (guard >= 5) || ($urandom_range(0, 99) < rdy_pct);
      #1;
      pending = (exp_q.size() > 0) && (exp_q[0].avail <= cyc);
      exp_rdy = !((pos == NB - 1) && pending && !out_ready);
      chk("link_ready", {63'd0, link_ready_out}, {63'd0, exp_rdy});
      acc = link_ready_out;
      guard++;
      if (!acc && guard > 50) begin
        checks++;
        errors++;
        $display("FAIL beat_accept_timeout: got no accept want accept within 50 cycles");
        return;
      end
    end
    if (last && pos == NB - 1) begin
      ee.avail = cyc + 1;
      exp_q.push_back(ee);
      pos = 0;
    end else if (last || pos == NB - 1) begin
      err_q.push_back(cyc + 1);
      err_total++;
      pos = 0;
    end else begin
      pos++;
    end
  endtask

  task automatic send_packet(input logic [127:0] p, input int nbeats, input int last_at,
                             input exp_t e);
    for (int i = 0; i < nbeats; i++) begin
      if (idle_en && ($urandom_range(0, 3) == 0)) idle($urandom_range(1, 3));
      drive_beat(p[i*32 +: 32], (i == last_at), e);
    end
  endtask

  function automatic exp_t rand_fields();
    exp_t e;
    e.w     = 1'($urandom);
    e.dm    = 2'($urandom);
    e.ctrl  = {1'b0, 4'($urandom)};
    e.dst   = {32'd0, $urandom};
    e.data  = {32'd0, $urandom};
    e.src   = {32'd0, $urandom};
    e.avail = 0;
    return e;
  endfunction

  // Field layout of an AW=32 packet; unused bit 7 and bits above 103 stay random.
  function automatic logic [127:0] pack32(input exp_t e);
    logic [127:0] p;
    p = {$urandom, $urandom, $urandom, $urandom};
    p[0]      = e.w;
    p[2:1]    = e.dm;
    p[6:3]    = e.ctrl[3:0];
    p[39:8]   = e.dst[31:0];
    p[71:40]  = e.data[31:0];
    p[103:72] = e.src[31:0];
    return p;
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    link_valid_in = 1'b0;
    out_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    err_q.delete();
    pos = 0;
    err_total = 0;
    #1;
    chk("rst_link_ready", {63'd0, link_ready_out}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_frame_err", {63'd0, frame_err_out}, 64'd0);
    chk("rst_dst", {32'd0, dstaddr_out}, 64'd0);
    chk("rst_data", {32'd0, data_out}, 64'd0);
    chk("rst_src", {32'd0, srcaddr_out}, 64'd0);
    chk("rst_ctrl", {57'd0, write_out, datamode_out, ctrlmode_out}, 64'd0);
  endtask

  task automatic test64(input logic [191:0] p, input logic [63:0] exp_dst);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      v64 = 1'b1;
      d64 = p[i*32 +: 32];
      last64 = (i == 5);
      #1;
      chk("rdy64", {63'd0, rdy64}, 64'd1);
    end
    @(posedge clk); #1;
    v64 = 1'b0;
    last64 = 1'b0;
    chk("ov64", {63'd0, ov64}, 64'd1);
    chk("dst64", dst64, exp_dst);
    chk("data64", data64, p[103:40]);
    chk("src64", src64, p[135:72]);
    chk("hdr64", {56'd0, w64, dm64, ctrl64}, {56'd0, p[0], p[2:1], p[7:3]});
    chk("ferr64", {63'd0, ferr64}, 64'd0);
    @(posedge clk); #1;
    chk("ov64_fall", {63'd0, ov64}, 64'd0);
  endtask

  initial begin
    exp_t         e;
    logic [127:0] p;
    logic [191:0] p64;
    int           t0;
    int           wait_cnt;

    repeat (2) @(posedge clk);
    do_reset();

    // Known-answer packet with a ready consumer.
    rdy_pct = 100;
    e = '{w: 1'b1, dm: 2'd2, ctrl: 5'd0, dst: 64'h80000010, src: 64'h12345678,
          data: 64'hDEADBEEF, avail: 0};
    p = {32'h00000012, 32'h345678DE, 32'hADBEEF80, 32'h00001005};
    send_packet(p, NB, NB - 1, e);
    idle(2);

    // Stalled consumer: first packet held, second packet's final beat back-pressured.
    rdy_pct = 0;
    send_packet(p, NB, NB - 1, e);
    idle(5);
    e = rand_fields();
    send_packet(pack32(e), NB, NB - 1, e);
    rdy_pct = 100;
    idle(3);

    // Short packet then a good one; long packet then a good one.
    e = rand_fields();
    send_packet(pack32(e), 2, 1, e);
    e = rand_fields();
    send_packet(pack32(e), NB, NB - 1, e);
    e = rand_fields();
    send_packet(pack32(e), NB, -1, e);
    e = rand_fields();
    send_packet(pack32(e), NB, NB - 1, e);
    idle(2);

    // Reset mid-packet, then a clean packet.
    e = rand_fields();
    send_packet(pack32(e), 3, -1, e);
    do_reset();
    rdy_pct = 100;
    e = rand_fields();
    send_packet(pack32(e), NB, NB - 1, e);
    idle(2);

    // Back-to-back packets with a ready consumer take NB cycles each.
    t0 = cyc;
    for (int k = 0; k < 8; k++) begin
      e = rand_fields();
      send_packet(pack32(e), NB, NB - 1, e);
    end
    chk("throughput_cycles", 64'(cyc - t0), 64'(8 * NB));
    idle(2);

    // Random framing, gaps and back-pressure.
    idle_en = 1'b1;
    for (int k = 0; k < 300; k++) begin
      int kind;
      rdy_pct = $urandom_range(30, 100);
      e = rand_fields();
      kind = $urandom_range(0, 7);
      if (kind == 0) begin
        int nb;
        nb = $urandom_range(1, NB - 1);
        send_packet(pack32(e), nb, nb - 1, e);
      end else if (kind == 1) begin
        send_packet(pack32(e), NB, -1, e);
      end else begin
        send_packet(pack32(e), NB, NB - 1, e);
      end
    end
    idle_en = 1'b0;

`ifdef EMESH_RX_UNPACK_ERRCNT_EN
    rdy_pct = 100;
    for (int k = 0; k < 300; k++) begin
      e = rand_fields();
      send_packet(pack32(e), 1, 0, e);
    end
    idle(3);
    chk("err_count", {56'd0, err_count}, (err_total > 255) ? 64'd255 : 64'(err_total));
`endif

    rdy_pct = 100;
    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 50) begin
      idle(1);
      wait_cnt++;
    end
    idle(2);
    chk("drain_empty", 64'(exp_q.size()), 64'd0);

    // AW=64 decode: directed destination address, then a random packet.
    p64 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    p64[167:136] = 32'h01234567;
    p64[39:8]    = 32'h89ABCDEF;
    test64(p64, 64'h0123456789ABCDEF);
    p64 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    test64(p64, {p64[167:136], p64[39:8]});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
